// File: rtl/sequential_subtractor_64_bit_pkg.sv
// sequential_subtractor_64_bit_pkg: shared sizes, state encoding and counter-width helper
package sequential_subtractor_64_bit_pkg;
    localparam int WIDTH_D = 64;
    localparam int CHUNK_D = 16;
    localparam int NCHUNK = WIDTH_D / CHUNK_D;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int CNT_W = cnt_w(NCHUNK);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/full_adder_16_bit.sv
// full_adder_16_bit: combinational chunk-wide adder with carry in and carry out
module full_adder_16_bit #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         cout,
    output logic [W-1:0] sum
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
endmodule

// File: rtl/sequential_subtractor_64_bit.sv
// sequential_subtractor_64_bit: a - b - bin, one chunk per cycle through a registered carry
module sequential_subtractor_64_bit
    import sequential_subtractor_64_bit_pkg::*;
#(
    parameter int WIDTH = WIDTH_D,
    parameter int CHUNK = CHUNK_D
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);
    localparam int NCH = WIDTH / CHUNK;
    localparam int CW = cnt_w(NCH);

    state_t           r_state, w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic [WIDTH-1:0] r_a, r_b, r_wdiff, w_wdiff_nxt;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout, r_ovf;
    logic [CHUNK-1:0] w_sum;
    logic             w_cout;
    logic             w_last;

    assign w_last = r_cnt == CW'(NCH - 1);
    assign busy   = r_state == RUN;
    assign done   = r_state == DONE;
    assign diff   = r_diff;
    assign bout   = r_bout;
    assign ovf    = r_ovf;

    full_adder_16_bit #(.W(CHUNK)) u_fa (
        .a    (r_a[int'(r_cnt)*CHUNK +: CHUNK]),
        .b    (~r_b[int'(r_cnt)*CHUNK +: CHUNK]),
        .cin  (r_carry),
        .cout (w_cout),
        .sum  (w_sum)
    );

    // The final chunk lands in the same edge as the output copy, so outputs take the merged value
    always_comb begin
        w_wdiff_nxt = r_wdiff;
        w_wdiff_nxt[int'(r_cnt)*CHUNK +: CHUNK] = w_sum;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = start ? RUN : IDLE;
            RUN:     w_state_nxt = w_last ? DONE : RUN;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_wdiff <= '0;
            r_diff  <= '0;
            r_bout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (r_state == IDLE && start) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= ~bin;
            r_cnt   <= '0;
        end else if (r_state == RUN) begin
            r_wdiff <= w_wdiff_nxt;
            r_carry <= w_cout;
            r_cnt   <= r_cnt + 1'b1;
            if (w_last) begin
                r_diff <= w_wdiff_nxt;
                r_bout <= ~w_cout;
                r_ovf  <= (r_a[WIDTH-1] ^ r_b[WIDTH-1]) & (r_a[WIDTH-1] ^ w_wdiff_nxt[WIDTH-1]);
            end
        end
    end
endmodule

// File: tb/tb_sequential_subtractor_64_bit.sv
// tb_sequential_subtractor_64_bit: directed vectors with a queue scoreboard checked on every done pulse
module tb_sequential_subtractor_64_bit;
    logic        clk = 1'b0;
    logic        rst, start, bin;
    logic [63:0] a, b;
    logic        busy, done, bout, ovf;
    logic [63:0] diff;

    typedef struct {
        logic [63:0] d;
        logic        bo;
        logic        ov;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;

    sequential_subtractor_64_bit dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done) begin
            if (q.size() == 0) begin
                chk("done_without_op", {63'b0, done}, 64'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("diff", diff, e.d);
                chk("bout", {63'b0, bout}, {63'b0, e.bo});
                chk("ovf", {63'b0, ovf}, {63'b0, e.ov});
            end
        end
    end

    task automatic do_op(input logic [63:0] ia, input logic [63:0] ib, input logic ibin,
                         input logic [63:0] ed, input logic ebo, input logic eov, input bit disturb);
        int  n;
        bit  seen;
        exp_t e;
        e = '{ed, ebo, eov};
        q.push_back(e);
        @(negedge clk);
        a = ia; b = ib; bin = ibin; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (done) begin
                seen = 1;
                break;
            end
            if (busy) n++;
            if (disturb && i == 1) begin
                a = ~ia; b = ia; bin = ~ibin; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("done_seen", {63'b0, seen}, 64'd1);
        chk("busy_cycles", 64'(n), 64'd4);
        @(negedge clk);
        chk("done_one_cycle", {63'b0, done}, 64'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {63'b0, busy}, 64'd0);
        chk("rst_done", {63'b0, done}, 64'd0);
        chk("rst_diff", diff, 64'd0);
        chk("rst_bout", {63'b0, bout}, 64'd0);
        chk("rst_ovf", {63'b0, ovf}, 64'd0);
        rst = 1'b0;

        do_op(64'd473, 64'd345, 1'b0, 64'd128, 1'b0, 1'b0, 0);
        do_op(64'd345, 64'd473, 1'b0, 64'hFFFF_FFFF_FFFF_FF80, 1'b1, 1'b0, 0);
        do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 0);
        do_op(64'd16000000000000000000, 64'd10000000000000000000, 1'b0, 64'd6000000000000000000, 1'b0, 1'b0, 0);
        do_op(64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h8000_0000_0000_0000, 1'b1, 1'b1, 0);
        do_op(64'd0, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 0);
        do_op(64'h8000_0000_0000_0000, 64'd1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 0);
        do_op(64'h0000_0000_0001_0000, 64'd1, 1'b0, 64'h0000_0000_0000_FFFF, 1'b0, 1'b0, 0);
        do_op(64'h0001_0000_0000_0000, 64'h0000_0000_0000_0001, 1'b1, 64'h0000_FFFF_FFFF_FFFE, 1'b0, 1'b0, 0);

        do_op(64'd473, 64'd345, 1'b0, 64'd128, 1'b0, 1'b0, 1);
        repeat (8) @(negedge clk);

        @(negedge clk);
        a = 64'd1000; b = 64'd1; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", {63'b0, busy}, 64'd0);
        chk("abort_done", {63'b0, done}, 64'd0);
        chk("abort_diff", diff, 64'd0);
        chk("abort_bout", {63'b0, bout}, 64'd0);
        chk("abort_ovf", {63'b0, ovf}, 64'd0);
        repeat (8) @(negedge clk);

        do_op(64'd1000, 64'd1, 1'b0, 64'd999, 1'b0, 1'b0, 0);
        repeat (3) @(negedge clk);
        chk("queue_drained", 64'(q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/sequential_subtractor_64_bit.md
# sequential_subtractor_64_bit

Multi-cycle 64-bit two's-complement subtractor that computes `a - b - bin` over four clock cycles, processing one 16-bit chunk per cycle with a registered carry chain. It is the inverse-direction companion to the team's combinational 64-bit full adder and sits in the datapath wherever a subtraction can tolerate latency in exchange for a short critical path. A start/busy/done handshake frames each operation. Results are held stable until the next operation completes.

## Interface
Parameters:
- `WIDTH`, default 64: operand width. Must be a multiple of `CHUNK`.
- `CHUNK`, default 16: bits processed per cycle. `NCHUNK = WIDTH/CHUNK`, which is 4 by default.

Ports:
- `clk`, input, 1 bit: the single clock. All state changes on the rising edge.
- `rst`, input, 1 bit: synchronous, active-high reset.
- `start`, input, 1 bit: request a new operation. Sampled only in IDLE.
- `a`, input, WIDTH bits: minuend. Captured on the accepted start.
- `b`, input, WIDTH bits: subtrahend. Captured on the accepted start.
- `bin`, input, 1 bit: borrow-in. Captured on the accepted start.
- `busy`, output, 1 bit: high while the block is in RUN.
- `done`, output, 1 bit: one-cycle pulse meaning the result outputs have just been updated.
- `diff`, output, WIDTH bits: `(a - b - bin) mod 2^WIDTH`.
- `bout`, output, 1 bit: unsigned borrow-out. 1 iff `a < b + bin`, treating operands as unsigned.
- `ovf`, output, 1 bit: signed overflow.

## Operation
- The arithmetic is `diff = a + ~b + ~bin`, computed chunk by chunk from LSB to MSB. The internal carry register is initialised to `~bin`.
- Each chunk step computes `{c, s} = a_chunk + ~b_chunk + c`, with all sums `CHUNK+1` bits wide.
- `bout = ~c_final`.
- `ovf = (a[W-1] ^ b[W-1]) & (a[W-1] ^ diff[W-1])`, evaluated on the latched operands.
- **IDLE:**
  - `start=1` latches `a`, `b` and `bin` into working registers.
  - It sets `carry = ~bin` and `cnt = 0`, then moves to RUN.
  - `start=0` leaves the state in IDLE.
- **RUN:**
  - Each cycle processes chunk `cnt`, writes the working difference register, updates `carry` and increments `cnt`.
  - When `cnt == NCHUNK-1`, the state moves to DONE.
  - `start` is ignored; the operands are already latched, so input changes have no effect.
- **DONE:**
  - The working difference is copied to `diff`, `bout` and `ovf` at the edge entering DONE.
  - `done=1` for exactly this one cycle.
  - The next state is always IDLE. `start` is not accepted in DONE.
- `diff`, `bout` and `ovf` change only on entry to DONE. Intermediate chunk values are never visible on the outputs.
- `busy = (state == RUN)`. `done = (state == DONE)`.

## Timing
- Reset values: state = IDLE, `busy=0`, `done=0`, `diff=0`, `bout=0`, `ovf=0`, `cnt=0`, `carry=0`.
- Latency:
  - `start` is accepted at edge E0.
  - `busy` is high after E0 through E4.
  - Results and `done=1` are valid after E4 (E4 is the fourth edge after E0).
  - `done` falls after E5.
- Throughput: the earliest next accepted start is at E6, because the block must be back in IDLE. One operation takes 6 cycles.
- If `rst` is asserted mid-RUN or in DONE, the block returns to IDLE with all outputs at their reset values on that edge. The partial result is discarded and no `done` pulse is issued.
- If `rst` and `start` are high on the same edge, reset wins.
- Wrap-around: modulo `2^WIDTH` with no saturation. The borrow and overflow flags report the wrap.

## Structure
- The shared package holds:
  - the `WIDTH` and `CHUNK` defaults, and the derived `NCHUNK`;
  - the state encoding `IDLE=2'd0`, `RUN=2'd1`, `DONE=2'd2`;
  - the counter width `$clog2(NCHUNK)`.
- One sub-module, `full_adder_16_bit`, is a combinational CHUNK-wide ripple adder with ports `a`, `b`, `cin`, `cout`, `sum`. The top level instantiates it once, feeds it `~b_chunk`, and muxes the operand chunk by `cnt`.
- The top level owns the FSM, the chunk counter, the carry register, the working registers and the output registers.

## Test plan
- `a=473`, `b=345`, `bin=0`, one start → after 4 edges, `done=1`, `diff=128`, `bout=0`, `ovf=0`. `busy` is high for exactly 4 cycles.
- `a=345`, `b=473`, `bin=0` → `diff=18446744073709551488`, `bout=1`, `ovf=0`.
- `a=b=18446744073709551615`, `bin=1` → `diff=18446744073709551615`, `bout=1`, `ovf=0`. Then `a=16000000000000000000`, `b=10000000000000000000`, `bin=0` → `diff=6000000000000000000`, `bout=0`, `ovf=0`.
- `a=0x7FFFFFFFFFFFFFFF`, `b=0xFFFFFFFFFFFFFFFF`, `bin=0` → `diff=0x8000000000000000`, `ovf=1`, `bout=1`.
- Start-while-busy and reset mid-operation:
  - Pulse `start` with new operands during RUN → ignored. The first result completes unchanged and only one `done` pulse is issued.
  - Assert `rst` at the second RUN cycle → IDLE, all outputs 0, and no `done`.
  - Start again after reset → correct result.
